rom_arbiter: RTL

//  Shares the single combinational instruction ROM read port between two requesters:
//  A = instruction fetch, B = data load / debug reader. Requests use a valid/ready handshake.

---
 rtl/rom_arbiter.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/rom_arbiter.sv
// rom_arbiter: shares one combinational instruction-ROM read port between
// requester A (instruction fetch) and requester B (data load / debug reader).
// One access is outstanding at a time. Each grant produces one registered
// response that is held until the owning requester accepts it.
module rom_arbiter #(
  parameter int ADDRESS_WIDTH  = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int ROM_WORDS      = 256,
  parameter bit FIXED_PRIORITY = 1'b0
) (
  input  logic                     clock,
  input  logic                     reset_n,

  // Requester A: instruction fetch
  input  logic                     a_valid,
  input  logic [ADDRESS_WIDTH-1:0] a_address,
  output logic                     a_ready,
  output logic                     a_resp_valid,
  output logic [DATA_WIDTH-1:0]    a_resp_data,
  output logic                     a_resp_error,
  input  logic                     a_resp_ready,

  // Requester B: data load / debug reader
  input  logic                     b_valid,
  input  logic [ADDRESS_WIDTH-1:0] b_address,
  output logic                     b_ready,
  output logic                     b_resp_valid,
  output logic [DATA_WIDTH-1:0]    b_resp_data,
  output logic                     b_resp_error,
  input  logic                     b_resp_ready,

  // ROM read port
  output logic [ADDRESS_WIDTH-1:0] rom_address,
  input  logic [DATA_WIDTH-1:0]    rom_read_data
);

  typedef enum logic {
    IDLE,
    RESPOND
  } state_t;

  typedef enum logic {
    REQ_A,
    REQ_B
  } req_t;

  state_t state;
  state_t state_next;
  req_t   owner;
  req_t   last_grant;

  logic   grant_a;
  logic   grant_b;
  logic   grant_error;
  logic   owner_accept;

  // Misaligned byte address or word index past the end of the ROM.
  function automatic logic address_error(input logic [ADDRESS_WIDTH-1:0] address);
    logic [ADDRESS_WIDTH-1:0] word_index;
    word_index = address >> 2;
    return (address[1:0] != 2'b00) ||
           (word_index >= ADDRESS_WIDTH'(ROM_WORDS));
  endfunction

  // Arbitration: grants only from IDLE; a tie goes to A under fixed priority,
  // otherwise to whichever requester was not granted last.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (state == IDLE) begin
      if (a_valid && b_valid) begin
        if (FIXED_PRIORITY || (last_grant == REQ_B)) begin
          grant_a = 1'b1;
        end else begin
          grant_b = 1'b1;
        end
      end else begin
        grant_a = a_valid;
        grant_b = b_valid;
      end
    end
  end

  // The owner's accept ends RESPOND; the other requester's resp_ready is ignored.
  always_comb begin
    owner_accept = 1'b0;
    if (state == RESPOND) begin
      owner_accept = (owner == REQ_A) ? a_resp_ready : b_resp_ready;
    end
  end

  // State register plus owner / last-grant bookkeeping.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      owner      <= REQ_A;
      last_grant <= REQ_B;
    end else begin
      state <= state_next;
      if (grant_a) begin
        owner      <= REQ_A;
        last_grant <= REQ_A;
      end else if (grant_b) begin
        owner      <= REQ_B;
        last_grant <= REQ_B;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (grant_a || grant_b) begin
          state_next = RESPOND;
        end
      end
      RESPOND: begin
        if (owner_accept) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Handshake outputs and ROM address; the address is driven only while granting.
  always_comb begin
    a_ready     = grant_a;
    b_ready     = grant_b;
    rom_address = '0;
    if (grant_a) begin
      rom_address = a_address;
    end else if (grant_b) begin
      rom_address = b_address;
    end
  end

  // Error classification of the address currently presented to the ROM.
  always_comb begin
    grant_error = address_error(rom_address);
  end

  // Requester A response register: loaded on grant, cleared on owner accept.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      a_resp_valid <= 1'b0;
      a_resp_error <= 1'b0;
      a_resp_data  <= '0;
    end else if (grant_a) begin
      a_resp_valid <= 1'b1;
      a_resp_error <= grant_error;
      a_resp_data  <= grant_error ? '0 : rom_read_data;
    end else if (owner_accept && (owner == REQ_A)) begin
      a_resp_valid <= 1'b0;
      a_resp_error <= 1'b0;
      a_resp_data  <= '0;
    end
  end

  // Requester B response register: loaded on grant, cleared on owner accept.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      b_resp_valid <= 1'b0;
      b_resp_error <= 1'b0;
      b_resp_data  <= '0;
    end else if (grant_b) begin
      b_resp_valid <= 1'b1;
      b_resp_error <= grant_error;
      b_resp_data  <= grant_error ? '0 : rom_read_data;
    end else if (owner_accept && (owner == REQ_B)) begin
      b_resp_valid <= 1'b0;
      b_resp_error <= 1'b0;
      b_resp_data  <= '0;
    end
  end

endmodule
